// File: rtl/shift_sequencer.sv
// Multicycle sequencer for the R-type shift unit.
// Accepts an op/amount on a start pulse in IDLE, issues one LOAD cycle,
// then as many SHIFT passes as the amount needs (each at most STEP_MAX),
// then a WRITE cycle that commits the result. Illegal ops go to FAULT.
// All outputs are a Moore decode of registered state, so no input reaches
// an output combinationally.
module shift_sequencer #(
  parameter int STEP_MAX = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [4:0] shamt,
  input  logic [4:0] rs_amt,
  output logic       shift_reset,
  output logic [2:0] shift_funct,
  output logic [4:0] shift_n,
  output logic       busy,
  output logic       rd_write,
  output logic       done,
  output logic       err,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_WRITE = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam logic [4:0] STEP_L = 5'(STEP_MAX);

  localparam logic [2:0] F_HOLD = 3'b000;
  localparam logic [2:0] F_LOAD = 3'b001;
  localparam logic [2:0] F_SHL  = 3'b010;
  localparam logic [2:0] F_SHRL = 3'b011;
  localparam logic [2:0] F_SHRA = 3'b100;

  state_t     state_q;
  logic [2:0] op_q;
  logic [4:0] amt_q;
  logic [4:0] rem_q;
  logic [4:0] step;

  // Distance of one pass: the remaining amount, saturated at what the
  // shift unit can do at once. Never exceeds rem, so rem cannot underflow.
  function automatic logic [4:0] sat_step(input logic [4:0] rem);
    return (rem > STEP_L) ? STEP_L : rem;
  endfunction

  assign step = sat_step(rem_q);

  // State, latched operands and the remaining-distance counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_CLEAR;
      op_q    <= '0;
      amt_q   <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        S_CLEAR: state_q <= S_IDLE;
        S_IDLE: begin
          if (start) begin
            if (op <= 3'd5) begin
              op_q    <= op;
              amt_q   <= (op < 3'd3) ? shamt : rs_amt;
              state_q <= S_LOAD;
            end else begin
              state_q <= S_FAULT;
            end
          end
        end
        S_LOAD: begin
          rem_q   <= amt_q;
          state_q <= (amt_q == 5'd0) ? S_WRITE : S_SHIFT;
        end
        S_SHIFT: begin
          rem_q <= rem_q - step;
          if (rem_q == step) state_q <= S_WRITE;
        end
        S_WRITE: state_q <= S_IDLE;
        S_FAULT: state_q <= S_IDLE;
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  // Moore output decode from registered state, latched op and counter.
  always_comb begin
    shift_reset = 1'b0;
    shift_funct = F_HOLD;
    shift_n     = 5'd0;
    busy        = 1'b0;
    rd_write    = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    state_out   = state_q;
    case (state_q)
      S_CLEAR: shift_reset = 1'b1;
      S_LOAD: begin
        shift_funct = F_LOAD;
        busy        = 1'b1;
      end
      S_SHIFT: begin
        busy    = 1'b1;
        shift_n = step;
        case (op_q)
          3'd0, 3'd3: shift_funct = F_SHL;
          3'd1, 3'd4: shift_funct = F_SHRL;
          default:    shift_funct = F_SHRA;
        endcase
      end
      S_WRITE: begin
        busy     = 1'b1;
        rd_write = 1'b1;
        done     = 1'b1;
      end
      S_FAULT: begin
        busy = 1'b1;
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
